// File: rtl/cache_wb_ctrl.sv
// Write-back, write-allocate cache controller, 1- or 2-way set-associative, with a per-word
// handshaked memory port for write-back/refill and saturating hit/miss counters.
module cache_wb_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic              stall,
    output logic [DATA_W-1:0] DataOut,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    // state | meaning
    // IDLE  | serve hits; on a miss latch the victim and start the line transfer
    // WB    | write the dirty victim line back, one word per mem_ack
    // FILL  | fetch the requested line into the victim way, one word per mem_ack
    // ALLOC | mark the refilled line valid and clean, then retry the access as a hit
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = SETS << OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {IDLE, WB, FILL, ALLOC} state_t;
    state_t state, stateNext;

    logic [DATA_W-1:0]   dataArr [WAYS][WORDS];
    logic [TAG_W-1:0]    tagArr [WAYS][SETS];
    logic [WAYS-1:0]     validArr [SETS];
    logic [WAYS-1:0]     dirtyArr [SETS];
    logic [SETS-1:0]     lruBits;

    logic [TAG_W-1:0]    reqTag, vTag, mTag;
    logic [INDEX_W-1:0]  reqIdx, mIdx;
    logic [OFFSET_W-1:0] reqOff, beat;
    logic                vWay, hitWay, victimSel, hitAny, victimDirty;
    logic                access, beatAck, fillGap, stallInt;

    assign reqTag  = WordAddress[ADDR_W-1 -: TAG_W];
    assign reqIdx  = WordAddress[OFFSET_W +: INDEX_W];
    assign reqOff  = WordAddress[OFFSET_W-1:0];
    assign access  = MemRead | MemWrite;
    assign beatAck = mem_req & mem_ack;

    // Victim is the lowest invalid way, otherwise the LRU way
    always_comb begin
        hitAny = 1'b0;
        hitWay = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[reqIdx][w] && tagArr[w][reqIdx] == reqTag) begin
                hitAny = 1'b1;
                hitWay = 1'(w);
            end
        end
        victimSel = (WAYS == 1) ? 1'b0 : lruBits[reqIdx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validArr[reqIdx][w]) victimSel = 1'(w);
        end
        victimDirty = validArr[reqIdx][victimSel] && dirtyArr[reqIdx][victimSel];
    end

    always_comb begin
        stateNext = state;
        stallInt  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (access && !hitAny) begin
                    stallInt  = 1'b1;
                    stateNext = victimDirty ? WB : FILL;
                end
            end
            WB: begin
                stallInt  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vTag, mIdx, beat};
                mem_wdata = dataArr[vWay][{mIdx, beat}];
                if (beatAck && beat == LAST_BEAT) stateNext = FILL;
            end
            FILL: begin
                // one idle cycle after write-back so mem_req drops between phases
                stallInt = 1'b1;
                mem_req  = !fillGap;
                mem_addr = {mTag, mIdx, beat};
                if (beatAck && beat == LAST_BEAT) stateNext = ALLOC;
            end
            ALLOC: begin
                stallInt  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Reset must release a held core request immediately, even mid-miss
    assign stall   = stallInt & RST;
    assign DataOut = (state == IDLE && MemRead && hitAny) ? dataArr[hitWay][{reqIdx, reqOff}] : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            lruBits    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            vWay       <= 1'b0;
            vTag       <= '0;
            mTag       <= '0;
            mIdx       <= '0;
            beat       <= '0;
            fillGap    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
            end
        end else begin
            state   <= stateNext;
            fillGap <= (state == WB) && beatAck && (beat == LAST_BEAT);
            if (state == IDLE && access) begin
                if (hitAny) begin
                    lruBits[reqIdx] <= ~hitWay;
                    if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                    if (MemWrite) dirtyArr[reqIdx][hitWay] <= 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                    vWay <= victimSel;
                    vTag <= tagArr[victimSel][reqIdx];
                    mTag <= reqTag;
                    mIdx <= reqIdx;
                    beat <= '0;
                end
            end
            if (beatAck) beat <= beat + OFFSET_W'(1);
            if (state == ALLOC) begin
                validArr[mIdx][vWay] <= 1'b1;
                dirtyArr[mIdx][vWay] <= 1'b0;
                lruBits[mIdx]        <= ~vWay;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && access && hitAny && MemWrite) dataArr[hitWay][{reqIdx, reqOff}] <= DataIn;
        if (state == FILL && beatAck) dataArr[vWay][{mIdx, beat}] <= mem_rdata;
        if (state == ALLOC) tagArr[vWay][mIdx] <= mTag;
    end
endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Bench for cache_wb_ctrl: three builds (2-way, 1-way, 2-bit counters) behind a
// 1-cycle-ack memory model returning the beat address as data.
`timescale 1ns/1ps
module tb_cache_wb_ctrl;
    logic        clk = 1'b0;
    logic        rstN;
    logic        rd [3];
    logic        wr [3];
    logic [9:0]  addr [3];
    logic [31:0] din [3];
    logic        stall [3];
    logic [31:0] dout [3];
    logic        memReq [3];
    logic        memWe [3];
    logic [9:0]  memAddr [3];
    logic [31:0] memWdata [3];
    logic        memAck [3];
    logic [15:0] hitCnt [3];
    logic [15:0] missCnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int WY = (g == 1) ? 1 : 2;
        localparam int CW = (g == 2) ? 2 : 16;
        logic [CW-1:0] hc, mc;
        logic          ack = 1'b0;
        logic [31:0]   rdata = '0;
        cache_wb_ctrl #(.ADDR_W(10), .DATA_W(32), .INDEX_W(3), .OFFSET_W(2),
                        .WAYS(WY), .CNT_W(CW)) u (
            .CLK(clk), .RST(rstN), .MemRead(rd[g]), .MemWrite(wr[g]),
            .WordAddress(addr[g]), .DataIn(din[g]), .stall(stall[g]), .DataOut(dout[g]),
            .mem_req(memReq[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
            .mem_wdata(memWdata[g]), .mem_rdata(rdata), .mem_ack(ack),
            .hit_count(hc), .miss_count(mc));
        always @(posedge clk) begin
            ack   <= memReq[g] && !ack;
            rdata <= {22'b0, memAddr[g]};
        end
        assign memAck[g]  = ack;
        assign hitCnt[g]  = 16'(hc);
        assign missCnt[g] = 16'(mc);
    end

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [9:0]  a;
        logic [31:0] wd;
        bit          miss;
        bit          wb;
        logic [9:0]  wbBase;
        logic [31:0] exp;
    } vec_t;

    beat_t       expQ [$];
    vec_t        vecs [$];
    logic [31:0] shadow [1024];
    int          expHit [3];
    int          expMiss [3];
    int          nRun = 0;
    int          nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nRun++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic int satInc(input int v, input int d);
        int mx;
        mx = (d == 2) ? 3 : 65535;
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic checkBeat();
        beat_t e;
        if (expQ.size() == 0) begin
            nRun++;
            nFail++;
            $display("FAIL beat_unexpected got addr=%h we=%b want none", memAddr[0], memWe[0]);
        end else begin
            e = expQ.pop_front();
            check("beat_addr", 32'(memAddr[0]), 32'(e.addr));
            check("beat_we", 32'(memWe[0]), 32'(e.we));
            if (e.we) check("beat_wdata", memWdata[0], e.wdata);
        end
    endtask

    task automatic doAccess(input vec_t v);
        int cyc;
        rd[v.d]   = v.r;
        wr[v.d]   = v.w;
        addr[v.d] = v.a;
        din[v.d]  = v.wd;
        @(negedge clk);
        check("stall_first", 32'(stall[v.d]), 32'(v.miss));
        if (!v.miss) check("hit_no_memreq", 32'(memReq[v.d]), 32'd0);
        cyc = 0;
        while (stall[v.d] && cyc < 200) begin
            if (v.d == 0 && memReq[0] && memAck[0]) checkBeat();
            @(negedge clk);
            cyc++;
        end
        if (stall[v.d]) begin
            nRun++;
            nFail++;
            $display("FAIL stall_timeout got stall=1 after %0d cycles want 0", cyc);
        end
        if (v.r && !v.w) check("data_out", dout[v.d], v.exp);
        @(posedge clk);
        #1;
        rd[v.d] = 1'b0;
        wr[v.d] = 1'b0;
        expHit[v.d] = satInc(expHit[v.d], v.d);
        if (v.miss) expMiss[v.d] = satInc(expMiss[v.d], v.d);
        check("hit_count", 32'(hitCnt[v.d]), 32'(expHit[v.d]));
        check("miss_count", 32'(missCnt[v.d]), 32'(expMiss[v.d]));
        if (v.d == 0) check("sb_drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic runVec(input vec_t v);
        beat_t       b;
        logic [9:0]  fb;
        fb = v.a & 10'h3FC;
        if (v.d == 0 && v.miss) begin
            if (v.wb) begin
                for (int k = 0; k < 4; k++) begin
                    b.we    = 1'b1;
                    b.addr  = v.wbBase + 10'(k);
                    b.wdata = shadow[v.wbBase + 10'(k)];
                    expQ.push_back(b);
                end
            end
            for (int k = 0; k < 4; k++) begin
                b.we    = 1'b0;
                b.addr  = fb + 10'(k);
                b.wdata = '0;
                expQ.push_back(b);
                shadow[fb + 10'(k)] = {22'b0, fb + 10'(k)};
            end
        end
        if (v.d == 0 && v.w) shadow[v.a] = v.wd;
        doAccess(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
            expHit[i] = 0; expMiss[i] = 0;
        end
        for (int i = 0; i < 1024; i++) shadow[i] = 32'(i);

        vecs.push_back('{0, 1, 0, 10'h3FF, 32'h0,    1, 0, 10'h0,   32'h3FF});
        vecs.push_back('{0, 0, 1, 10'h3FE, 32'hA5,   0, 0, 10'h0,   32'h0});
        vecs.push_back('{0, 1, 0, 10'h3FE, 32'h0,    0, 0, 10'h0,   32'hA5});
        vecs.push_back('{0, 1, 0, 10'h1FC, 32'h0,    1, 0, 10'h0,   32'h1FC});
        vecs.push_back('{0, 1, 0, 10'h0FC, 32'h0,    1, 1, 10'h3FC, 32'h0FC});
        vecs.push_back('{0, 1, 0, 10'h1FC, 32'h0,    0, 0, 10'h0,   32'h1FC});
        vecs.push_back('{0, 0, 1, 10'h0FD, 32'h1234, 0, 0, 10'h0,   32'h0});
        vecs.push_back('{0, 1, 0, 10'h011, 32'h0,    1, 0, 10'h0,   32'h011});
        vecs.push_back('{0, 1, 0, 10'h0FD, 32'h0,    0, 0, 10'h0,   32'h1234});
        vecs.push_back('{0, 1, 0, 10'h2FE, 32'h0,    1, 0, 10'h0,   32'h2FE});
        vecs.push_back('{0, 1, 0, 10'h3FC, 32'h0,    1, 1, 10'h0FC, 32'h3FC});
        vecs.push_back('{0, 1, 1, 10'h3FC, 32'h77,   0, 0, 10'h0,   32'h0});
        vecs.push_back('{0, 1, 0, 10'h3FC, 32'h0,    0, 0, 10'h0,   32'h77});
        vecs.push_back('{0, 1, 0, 10'h2FE, 32'h0,    0, 0, 10'h0,   32'h2FE});
        vecs.push_back('{0, 0, 1, 10'h200, 32'hBEEF, 1, 0, 10'h0,   32'h0});
        vecs.push_back('{0, 1, 0, 10'h200, 32'h0,    0, 0, 10'h0,   32'hBEEF});
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) vecs.push_back('{1, 1, 0, 10'h3FC, 32'h0, 1, 0, 10'h0, 32'h3FC});
            else            vecs.push_back('{1, 1, 0, 10'h1FC, 32'h0, 1, 0, 10'h0, 32'h1FC});
        end
        vecs.push_back('{2, 1, 0, 10'h3FC, 32'h0, 1, 0, 10'h0, 32'h3FC});
        for (int i = 0; i < 5; i++) vecs.push_back('{2, 1, 0, 10'h3FD, 32'h0, 0, 0, 10'h0, 32'h3FD});

        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall[0]), 32'd0);
        check("rst_dataout", dout[0], 32'd0);
        check("rst_mem_req", 32'(memReq[0]), 32'd0);
        check("rst_mem_we", 32'(memWe[0]), 32'd0);
        check("rst_mem_addr", 32'(memAddr[0]), 32'd0);
        check("rst_mem_wdata", memWdata[0], 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rst_hit_count", 32'(hitCnt[i]), 32'd0);
            check("rst_miss_count", 32'(missCnt[i]), 32'd0);
        end
        @(posedge clk);
        #1 rstN = 1'b1;

        foreach (vecs[i]) runVec(vecs[i]);

        // reset in the middle of a refill, with the read still held
        rd[0] = 1'b1;
        addr[0] = 10'h155;
        cyc = 0;
        @(negedge clk);
        while (!(memReq[0] && memAddr[0] == 10'h156 && !memAck[0]) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("midfill_beat2_addr", 32'(memAddr[0]), 32'h156);
        #1 rstN = 1'b0;
        #1;
        check("midfill_rst_mem_req", 32'(memReq[0]), 32'd0);
        check("midfill_rst_stall", 32'(stall[0]), 32'd0);
        check("midfill_rst_miss_count", 32'(missCnt[0]), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        expHit[0] = 0;
        expMiss[0] = 0;
        for (int k = 0; k < 4; k++) shadow[10'h154 + k] = 32'h154 + 32'(k);
        runVec('{0, 1, 0, 10'h155, 32'h0, 1, 0, 10'h0, 32'h155});

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
